// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap entry / mret sequencer driving a single-port CSR file.
// Latency: trap redirect on cycle 6 after acceptance (7 with CSR_TRAP_MTVAL_EN), mret redirect on cycle 4.
// Backpressure: stall_i[3] freezes the sequencer and suppresses CSR writes and redirect pulses.
// Optional feature macro: CSR_TRAP_MTVAL_EN adds a WR_MTVAL step (mtval <= 0) to the trap path.
module csr_trap_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall_i,
   output logic        stallreq_o,
   input  logic        ecall_i,
   input  logic        mret_i,
   input  logic [63:0] inst_pc_i,
   output logic        csr_re_o,
   output logic [11:0] csr_raddr_o,
   input  logic [63:0] csr_rdata_i,
   output logic        csr_we_o,
   output logic [11:0] csr_waddr_o,
   output logic [63:0] csr_wdata_o,
   output logic        redirect_valid_o,
   output logic [63:0] redirect_pc_o,
   output logic        busy_o
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MTVAL   = 12'h343;
   localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_RD_MSTATUS = 4'd1,
      S_WR_MEPC    = 4'd2,
      S_WR_MCAUSE  = 4'd3,
      S_WR_MTVAL   = 4'd4,
      S_WR_MSTATUS = 4'd5,
      S_RD_MTVEC   = 4'd6,
      S_RD_MEPC    = 4'd7,
      S_REDIRECT   = 4'd8
   } state_t;

   typedef enum logic {
      K_TRAP = 1'b0,
      K_RET  = 1'b1
   } kind_t;

   state_t      state_q, state_d;
   kind_t       kind_q, kind_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] mstatus_q, mstatus_d;
   logic [63:0] target_q, target_d;

   logic        adv;
   logic        req;
   logic [63:0] mstatus_new;

   logic        stallreq_c;
   logic        re_c;
   logic [11:0] raddr_c;
   logic        we_c;
   logic [11:0] waddr_c;
   logic [63:0] wdata_c;
   logic        rvld_c;
   logic [63:0] rpc_c;

   // Only the memory-stage stall bit matters to this block.
   logic unused_stall;
   assign unused_stall = ^{stall_i[5:4], stall_i[2:0]};

   assign adv = ~stall_i[3];
   assign req = ecall_i | mret_i;

   // Updated mstatus image: trap pushes MIE into MPIE, return pops MPIE into MIE; MPP is always M.
   always_comb begin
      mstatus_new = mstatus_q;
      if (kind_q == K_TRAP) begin
         mstatus_new[7] = mstatus_q[3];
         mstatus_new[3] = 1'b0;
      end else begin
         mstatus_new[3] = mstatus_q[7];
         mstatus_new[7] = 1'b1;
      end
      mstatus_new[12:11] = 2'b11;
   end

   // Next-state and per-state CSR port / redirect drive; every step advances only when unstalled.
   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      pc_d       = pc_q;
      mstatus_d  = mstatus_q;
      target_d   = target_q;
      stallreq_c = 1'b0;
      re_c       = 1'b0;
      raddr_c    = '0;
      we_c       = 1'b0;
      waddr_c    = '0;
      wdata_c    = '0;
      rvld_c     = 1'b0;
      rpc_c      = '0;

      case (state_q)
         S_IDLE: begin
            if (req && adv) begin
               stallreq_c = 1'b1;
               state_d    = S_RD_MSTATUS;
               if (ecall_i) begin
                  kind_d = K_TRAP;
                  pc_d   = inst_pc_i;
               end else begin
                  kind_d = K_RET;
               end
            end
         end

         S_RD_MSTATUS: begin
            stallreq_c = 1'b1;
            re_c       = 1'b1;
            raddr_c    = ADDR_MSTATUS;
            if (adv) begin
               mstatus_d = csr_rdata_i;
               state_d   = (kind_q == K_TRAP) ? S_WR_MEPC : S_WR_MSTATUS;
            end
         end

         S_WR_MEPC: begin
            stallreq_c = 1'b1;
            if (adv) begin
               we_c    = 1'b1;
               waddr_c = ADDR_MEPC;
               wdata_c = pc_q;
               state_d = S_WR_MCAUSE;
            end
         end

         S_WR_MCAUSE: begin
            stallreq_c = 1'b1;
            if (adv) begin
               we_c    = 1'b1;
               waddr_c = ADDR_MCAUSE;
               wdata_c = CAUSE_ECALL_M;
`ifdef CSR_TRAP_MTVAL_EN
               state_d = S_WR_MTVAL;
`else
               state_d = S_WR_MSTATUS;
`endif
            end
         end

         S_WR_MTVAL: begin
`ifdef CSR_TRAP_MTVAL_EN
            stallreq_c = 1'b1;
            if (adv) begin
               we_c    = 1'b1;
               waddr_c = ADDR_MTVAL;
               wdata_c = '0;
               state_d = S_WR_MSTATUS;
            end
`else
            // Unreachable without the mtval step; recover quietly without writing.
            state_d = S_IDLE;
`endif
         end

         S_WR_MSTATUS: begin
            stallreq_c = 1'b1;
            if (adv) begin
               we_c    = 1'b1;
               waddr_c = ADDR_MSTATUS;
               wdata_c = mstatus_new;
               state_d = (kind_q == K_TRAP) ? S_RD_MTVEC : S_RD_MEPC;
            end
         end

         S_RD_MTVEC: begin
            stallreq_c = 1'b1;
            re_c       = 1'b1;
            raddr_c    = ADDR_MTVEC;
            if (adv) begin
               // Direct mode only: the mode field is dropped from the vector.
               target_d = {csr_rdata_i[63:2], 2'b00};
               state_d  = S_REDIRECT;
            end
         end

         S_RD_MEPC: begin
            stallreq_c = 1'b1;
            re_c       = 1'b1;
            raddr_c    = ADDR_MEPC;
            if (adv) begin
               target_d = csr_rdata_i;
               state_d  = S_REDIRECT;
            end
         end

         S_REDIRECT: begin
            if (adv) begin
               rvld_c  = 1'b1;
               rpc_c   = target_q;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and captured operands; synchronous reset abandons any sequence in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         kind_q    <= K_TRAP;
         pc_q      <= '0;
         mstatus_q <= '0;
         target_q  <= '0;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         pc_q      <= pc_d;
         mstatus_q <= mstatus_d;
         target_q  <= target_d;
      end
   end

   // Outputs are forced quiet while reset is held, so an aborted sequence cannot leak a write or redirect.
   assign stallreq_o       = stallreq_c & ~rst;
   assign busy_o           = (state_q != S_IDLE) & ~rst;
   assign csr_re_o         = re_c & ~rst;
   assign csr_raddr_o      = rst ? 12'd0 : raddr_c;
   assign csr_we_o         = we_c & ~rst;
   assign csr_waddr_o      = rst ? 12'd0 : waddr_c;
   assign csr_wdata_o      = rst ? 64'd0 : wdata_c;
   assign redirect_valid_o = rvld_c & ~rst;
   assign redirect_pc_o    = rst ? 64'd0 : rpc_c;

endmodule
